// File: rtl/pomdp_pkg.sv
// Shared definitions for the POMDP step sequencer.
// Provides the controller state encoding, the random-word and
// probability width, the action encodings and the Q0.16 probability type.
package pomdp_pkg;

    localparam int PROB_W         = 16;
    localparam int BELIEF_TIMEOUT = 64;

    typedef logic [PROB_W-1:0] prob_t;
    typedef logic [1:0]        action_t;

    localparam action_t ACT_0       = 2'd0;
    localparam action_t ACT_1       = 2'd1;
    localparam action_t ACT_2       = 2'd2;
    localparam action_t ACT_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_T = 3'd1,
        ST_TRANS   = 3'd2,
        ST_FETCH_O = 3'd3,
        ST_OBS     = 3'd4,
        ST_BELIEF  = 3'd5,
        ST_RESP    = 3'd6
    } ctrl_state_t;

endpackage

// File: rtl/step_watchdog.sv
// Cycle watchdog for the belief-update wait.
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - synchronous active-high reset
//   clear_i    - restart the count (takes priority over enable)
//   enable_i   - count one waiting cycle
//   expired_o  - high in the TIMEOUT-th enabled cycle after a clear
module step_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, then saturating increment while enabled.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != TERM)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of earlier enabled cycles, so the current
    // cycle is the TIMEOUT-th one when count_q reaches TIMEOUT-1.
    assign expired_o = enable_i && (count_q == TERM);

endmodule

// File: rtl/pomdp_step_ctrl.sv
// Sequencer for one POMDP simulation step.
// Accepts an action, fetches a random word, launches the transition
// sampler, fetches a second random word, drives obs_gen, waits (bounded)
// for the belief update and returns observation/state/error.
// Ports:
//   step_*   - request handshake (action 3 is rejected with an error)
//   rand_*   - random word handshake with the LFSR
//   trans_*  - transition sampler launch and result
//   obs_*    - obs_gen drive; en_belief_i/observation_i are its outputs
//   belief_done_i - belief update complete
//   result_* - response handshake; step_count_o counts error-free steps
module pomdp_step_ctrl #(
    parameter int PROB_W         = 16,
    parameter int BELIEF_TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              step_valid_i,
    output logic              step_ready_o,
    input  logic [1:0]        step_action_i,
    output logic              rand_req_o,
    input  logic              rand_valid_i,
    input  logic [PROB_W-1:0] rand_data_i,
    output logic              trans_en_o,
    output logic [1:0]        trans_action_o,
    output logic              trans_state_o,
    output logic [PROB_W-1:0] trans_random_o,
    input  logic              trans_done_i,
    input  logic              next_state_i,
    output logic              obs_en_o,
    output logic [1:0]        obs_action_o,
    output logic              obs_state_o,
    output logic [PROB_W-1:0] obs_random_o,
    input  logic              en_belief_i,
    input  logic              observation_i,
    input  logic              belief_done_i,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic              result_obs_o,
    output logic              result_state_o,
    output logic              result_err_o,
    output logic [15:0]       step_count_o
);

    import pomdp_pkg::*;

    ctrl_state_t       state_q,        state_d;
    logic [1:0]        action_q,       action_d;
    logic              cur_state_q,    cur_state_d;
    logic              obs_q,          obs_d;
    logic              trans_en_q,     trans_en_d;
    logic [1:0]        trans_action_q, trans_action_d;
    logic              trans_state_q,  trans_state_d;
    logic [PROB_W-1:0] trans_random_q, trans_random_d;
    logic              obs_en_q,       obs_en_d;
    logic [1:0]        obs_action_q,   obs_action_d;
    logic              obs_state_q,    obs_state_d;
    logic [PROB_W-1:0] obs_random_q,   obs_random_d;
    logic              result_obs_q,   result_obs_d;
    logic              result_state_q, result_state_d;
    logic              result_err_q,   result_err_d;
    logic [15:0]       step_count_q,   step_count_d;

    logic wd_clear_s;
    logic wd_en_s;
    logic wd_expired_s;

    step_watchdog #(
        .TIMEOUT (BELIEF_TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (wd_clear_s),
        .enable_i  (wd_en_s),
        .expired_o (wd_expired_s)
    );

    // Next-state and next-output logic; launch pulses and data are loaded
    // on the transition into TRANS/OBS so they appear in the entry cycle.
    always_comb begin
        state_d        = state_q;
        action_d       = action_q;
        cur_state_d    = cur_state_q;
        obs_d          = obs_q;
        trans_en_d     = 1'b0;
        trans_action_d = trans_action_q;
        trans_state_d  = trans_state_q;
        trans_random_d = trans_random_q;
        obs_en_d       = 1'b0;
        obs_action_d   = obs_action_q;
        obs_state_d    = obs_state_q;
        obs_random_d   = obs_random_q;
        result_obs_d   = result_obs_q;
        result_state_d = result_state_q;
        result_err_d   = result_err_q;
        step_count_d   = step_count_q;
        wd_clear_s     = 1'b0;
        wd_en_s        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (step_valid_i) begin
                    action_d = step_action_i;
                    if (step_action_i == ACT_ILLEGAL) begin
                        state_d        = ST_RESP;
                        result_err_d   = 1'b1;
                        result_obs_d   = 1'b0;
                        result_state_d = cur_state_q;
                    end else begin
                        state_d = ST_FETCH_T;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH_T: begin
                if (rand_valid_i) begin
                    state_d        = ST_TRANS;
                    trans_en_d     = 1'b1;
                    trans_action_d = action_q;
                    trans_state_d  = cur_state_q;
                    trans_random_d = rand_data_i;
                end else begin
                    state_d = ST_FETCH_T;
                end
            end
            ST_TRANS: begin
                if (trans_done_i) begin
                    state_d     = ST_FETCH_O;
                    cur_state_d = next_state_i;
                end else begin
                    state_d = ST_TRANS;
                end
            end
            ST_FETCH_O: begin
                if (rand_valid_i) begin
                    state_d      = ST_OBS;
                    obs_en_d     = 1'b1;
                    obs_action_d = action_q;
                    obs_state_d  = cur_state_q;
                    obs_random_d = rand_data_i;
                end else begin
                    state_d = ST_FETCH_O;
                end
            end
            ST_OBS: begin
                if (en_belief_i) begin
                    state_d    = ST_BELIEF;
                    obs_d      = observation_i;
                    wd_clear_s = 1'b1;
                end else begin
                    state_d = ST_OBS;
                end
            end
            ST_BELIEF: begin
                wd_en_s = 1'b1;
                // A completion in the expiry cycle still counts as success.
                if (belief_done_i) begin
                    state_d        = ST_RESP;
                    result_err_d   = 1'b0;
                    result_obs_d   = obs_q;
                    result_state_d = cur_state_q;
                end else if (wd_expired_s) begin
                    state_d        = ST_RESP;
                    result_err_d   = 1'b1;
                    result_obs_d   = obs_q;
                    result_state_d = cur_state_q;
                end else begin
                    state_d = ST_BELIEF;
                end
            end
            ST_RESP: begin
                if (result_ready_i) begin
                    state_d = ST_IDLE;
                    if (!result_err_q) begin
                        step_count_d = step_count_q + 16'd1;
                    end else begin
                        step_count_d = step_count_q;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any step in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            action_q       <= 2'd0;
            cur_state_q    <= 1'b0;
            obs_q          <= 1'b0;
            trans_en_q     <= 1'b0;
            trans_action_q <= 2'd0;
            trans_state_q  <= 1'b0;
            trans_random_q <= '0;
            obs_en_q       <= 1'b0;
            obs_action_q   <= 2'd0;
            obs_state_q    <= 1'b0;
            obs_random_q   <= '0;
            result_obs_q   <= 1'b0;
            result_state_q <= 1'b0;
            result_err_q   <= 1'b0;
            step_count_q   <= 16'd0;
        end else begin
            state_q        <= state_d;
            action_q       <= action_d;
            cur_state_q    <= cur_state_d;
            obs_q          <= obs_d;
            trans_en_q     <= trans_en_d;
            trans_action_q <= trans_action_d;
            trans_state_q  <= trans_state_d;
            trans_random_q <= trans_random_d;
            obs_en_q       <= obs_en_d;
            obs_action_q   <= obs_action_d;
            obs_state_q    <= obs_state_d;
            obs_random_q   <= obs_random_d;
            result_obs_q   <= result_obs_d;
            result_state_q <= result_state_d;
            result_err_q   <= result_err_d;
            step_count_q   <= step_count_d;
        end
    end

    // Handshake flags are pure decodes of the state register.
    assign step_ready_o   = (state_q == ST_IDLE);
    assign rand_req_o     = (state_q == ST_FETCH_T) || (state_q == ST_FETCH_O);
    assign result_valid_o = (state_q == ST_RESP);

    assign trans_en_o     = trans_en_q;
    assign trans_action_o = trans_action_q;
    assign trans_state_o  = trans_state_q;
    assign trans_random_o = trans_random_q;
    assign obs_en_o       = obs_en_q;
    assign obs_action_o   = obs_action_q;
    assign obs_state_o    = obs_state_q;
    assign obs_random_o   = obs_random_q;
    assign result_obs_o   = result_obs_q;
    assign result_state_o = result_state_q;
    assign result_err_o   = result_err_q;
    assign step_count_o   = step_count_q;

endmodule
